// File: rtl/reconfig_multi_pkg.sv
// Shared constants and state encoding for the reconfig_multi scheduler slice.
package reconfig_multi_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] K_S0 = 32'd12305;
  localparam logic [DATA_W-1:0] K_S1 = 32'd20746;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/reconfig_multi.sv
// Combinational constant multiplier: y = x * (s ? 20746 : 12305), truncated to 32 bits.
module reconfig_multi
  import reconfig_multi_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic              s,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] k;

  assign k = s ? K_S1 : K_S0;
  assign y = x * k;
endmodule

// File: rtl/reconfig_multi_sched.sv
// Round-robin two-requester front end for the shared reconfig_multi multiplier,
// with registered operands/result and per-requester completion counters.
module reconfig_multi_sched
  import reconfig_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_x,
  input  logic              req0_s,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_x,
  input  logic              req1_s,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_id,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1,
  output logic              busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; requesters hold valid/x/s until ready, the consumer sees
  // rsp_y/rsp_id stable while rsp_valid is high and rsp_ready is low.

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] op_x;
  logic              op_s;
  logic              op_id;
  logic              last_grant;
  logic              accept;
  logic              grant_id;
  logic              rsp_fire;
  logic [DATA_W-1:0] mult_y;

  reconfig_multi u_mult (
    .x (op_x),
    .s (op_s),
    .y (mult_y)
  );

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    grant_id   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester not granted last time wins.
        if (req0_valid && (!req1_valid || last_grant)) begin
          req0_ready = 1'b1;
          accept     = 1'b1;
          grant_id   = 1'b0;
          state_nxt  = CALC;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          accept     = 1'b1;
          grant_id   = 1'b1;
          state_nxt  = CALC;
        end
      end
      CALC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_x       <= '0;
      op_s       <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      done_cnt0  <= '0;
      done_cnt1  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_x       <= grant_id ? req1_x : req0_x;
        op_s       <= grant_id ? req1_s : req0_s;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state == CALC) begin
        rsp_y  <= mult_y;
        rsp_id <= op_id;
      end
      if (rsp_fire) begin
        if (rsp_id) done_cnt1 <= done_cnt1 + CNT_W'(1);
        else        done_cnt0 <= done_cnt0 + CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_reconfig_multi_sched.sv
// Self-checking bench for reconfig_multi_sched: directed scenarios plus a
// randomized run against a transaction-level model of the scheduler.
module tb_reconfig_multi_sched;
  import reconfig_multi_pkg::*;

  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_s, req0_ready;
  logic [31:0]       req0_x;
  logic              req1_valid, req1_s, req1_ready;
  logic [31:0]       req1_x;
  logic              rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0]       rsp_y;
  logic [CNT_W-1:0]  done_cnt0, done_cnt1;

  int tests = 0;
  int fails = 0;
  int cnt_m0 = 0;
  int cnt_m1 = 0;
  logic [32:0] exp_q[$];

  reconfig_multi_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_s(req0_s), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_s(req1_s), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_y(input logic [31:0] x, input logic s);
    logic [63:0] p;
    p = 64'(x) * (s ? 64'(K_S1) : 64'(K_S0));
    return p[31:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_m0 = 0; cnt_m1 = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_y !== 32'd0) begin fails++; $display("FAIL reset_rsp_y got %h exp 0", rsp_y); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    tests++; if (done_cnt0 !== '0 || done_cnt1 !== '0) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", done_cnt0, done_cnt1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic single_txn(input logic id, input logic [31:0] opx, input logic ops, input string tag);
    int w;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_x = opx; req1_s = ops; end
    else    begin req0_valid = 1'b1; req0_x = opx; req0_s = ops; end
    #1;
    w = 0;
    while ((id ? req1_ready : req0_ready) !== 1'b1 && w < 8) begin @(negedge clk); #1; w++; end
    tests++;
    if (w >= 8) begin
      fails++; $display("FAIL %s_accept got no ready exp ready within 8 cycles", tag);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    tests++; if ((id ? req0_ready : req1_ready) !== 1'b0) begin
      fails++; $display("FAIL %s_other_ready got 1 exp 0", tag); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL %s_t1 got valid=%b busy=%b exp valid=0 busy=1", tag, rsp_valid, busy); end
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL %s_latency got valid=%b exp 1 at T+2", tag, rsp_valid); end
    tests++; if (rsp_y !== model_y(opx, ops)) begin
      fails++; $display("FAIL %s_y got %h exp %h", tag, rsp_y, model_y(opx, ops)); end
    tests++; if (rsp_id !== id) begin fails++; $display("FAIL %s_id got %b exp %b", tag, rsp_id, id); end
    if (id) cnt_m1++; else cnt_m0++;
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_idle got valid=%b busy=%b exp 0/0", tag, rsp_valid, busy); end
    tests++; if (done_cnt0 !== CNT_W'(cnt_m0) || done_cnt1 !== CNT_W'(cnt_m1)) begin
      fails++; $display("FAIL %s_cnt got %0d/%0d exp %0d/%0d", tag, done_cnt0, done_cnt1, cnt_m0, cnt_m1); end
  endtask

  task automatic test_single();
    do_reset();
    single_txn(1'b0, 32'd1, 1'b0, "r0_x1");
    single_txn(1'b1, 32'h0001_0000, 1'b1, "r1_s1");
    single_txn(1'b0, 32'h0010_0000, 1'b0, "ovf");
    single_txn(1'b1, 32'hFFFF_FFFF, 1'b0, "allones");
    for (int i = 0; i < 6; i++)
      single_txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "rand_single");
  endtask

  task automatic test_alternate();
    int n;
    int c;
    logic eid;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_x = 32'd2; req0_s = 1'b0;
    req1_valid = 1'b1; req1_x = 32'd3; req1_s = 1'b1;
    rsp_ready = 1'b1;
    n = 0; c = 0;
    while (n < 6 && c < 40) begin
      #1;
      tests++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        fails++; $display("FAIL alt_two_ready got 11 exp at most one"); end
      if (rsp_valid === 1'b1) begin
        eid = n[0];
        tests++; if (rsp_id !== eid) begin fails++; $display("FAIL alt_id[%0d] got %b exp %b", n, rsp_id, eid); end
        tests++; if (rsp_y !== model_y(eid ? 32'd3 : 32'd2, eid)) begin
          fails++; $display("FAIL alt_y[%0d] got %0d exp %0d", n, rsp_y, model_y(eid ? 32'd3 : 32'd2, eid)); end
        n++;
      end
      if (n < 6) begin @(negedge clk); c++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (n != 6) begin fails++; $display("FAIL alt_count got %0d exp 6 responses", n); end
    @(negedge clk); #1;
    tests++; if (done_cnt0 !== CNT_W'(3) || done_cnt1 !== CNT_W'(3)) begin
      fails++; $display("FAIL alt_cnt got %0d/%0d exp 3/3", done_cnt0, done_cnt1); end
  endtask

  task automatic test_backpressure();
    logic [31:0] bx;
    logic bs;
    logic [31:0] ey;
    int w;
    do_reset();
    bx = $urandom; bs = 1'($urandom_range(0, 1)); ey = model_y(bx, bs);
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b1; req0_x = bx; req0_s = bs;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    w = 0;
    while (rsp_valid !== 1'b1 && w < 5) begin @(negedge clk); #1; w++; end
    tests++; if (w >= 5) begin fails++; $display("FAIL bp_rsp got no rsp_valid exp within 5 cycles"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; req0_x = $urandom; req1_x = $urandom;
      #1;
      tests++; if (rsp_valid !== 1'b1 || rsp_y !== ey || rsp_id !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%b y=%h id=%b exp v=1 y=%h id=0", i, rsp_valid, rsp_y, rsp_id, ey); end
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready[%0d] got %b%b exp 00", i, req0_ready, req1_ready); end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cnt_m0++;
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release got busy=%b valid=%b exp 0/0", busy, rsp_valid); end
    tests++; if (done_cnt0 !== CNT_W'(cnt_m0) || done_cnt1 !== '0) begin
      fails++; $display("FAIL bp_cnt got %0d/%0d exp %0d/0", done_cnt0, done_cnt1, cnt_m0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Accept from requester 0, then reset while in CALC.
    @(negedge clk);
    req0_valid = 1'b1; req0_x = $urandom; req0_s = 1'b0; rsp_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL rm_accept1 got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== '0 || done_cnt1 !== '0) begin
      fails++; $display("FAIL rm_calc got v=%b busy=%b cnt=%0d/%0d exp 0/0/0/0", rsp_valid, busy, done_cnt0, done_cnt1); end
    // Accept again, reset in RESP while the consumer is ready.
    @(negedge clk);
    req0_valid = 1'b1; req0_x = $urandom; req0_s = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL rm_accept2 got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rm_resp got %b exp 1", rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== '0 || done_cnt1 !== '0) begin
      fails++; $display("FAIL rm_resp_rst got v=%b busy=%b cnt=%0d/%0d exp 0/0/0/0", rsp_valid, busy, done_cnt0, done_cnt1); end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL rm_tie got %b%b exp r0=1 r1=0", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic pend0, pend1, ps0, ps1, inflight, last_m, e_r0, e_r1, e_rv;
    logic [31:0] px0, px1;
    int age;
    logic [32:0] head;
    do_reset();
    pend0 = 1'b0; pend1 = 1'b0; inflight = 1'b0; last_m = 1'b1; age = 0;
    px0 = '0; px1 = '0; ps0 = 1'b0; ps1 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!pend0 && $urandom_range(0, 2) == 0) begin pend0 = 1'b1; px0 = $urandom; ps0 = 1'($urandom_range(0, 1)); end
      if (!pend1 && $urandom_range(0, 2) == 0) begin pend1 = 1'b1; px1 = $urandom; ps1 = 1'($urandom_range(0, 1)); end
      req0_valid = pend0; req0_x = px0; req0_s = ps0;
      req1_valid = pend1; req1_x = px1; req1_s = ps1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!inflight) begin
        if (pend0 && pend1) begin e_r0 = last_m; e_r1 = !last_m; end
        else begin e_r0 = pend0; e_r1 = pend1; end
      end
      e_rv = inflight && (age >= 2);
      tests++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
        fails++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", cyc, req0_ready, req1_ready, e_r0, e_r1); end
      tests++; if (rsp_valid !== e_rv || busy !== inflight) begin
        fails++; $display("FAIL rnd_state[%0d] got v=%b busy=%b exp v=%b busy=%b", cyc, rsp_valid, busy, e_rv, inflight); end
      if (e_rv && exp_q.size() > 0) begin
        head = exp_q[0];
        tests++; if ({rsp_id, rsp_y} !== head) begin
          fails++; $display("FAIL rnd_rsp[%0d] got id=%b y=%h exp id=%b y=%h", cyc, rsp_id, rsp_y, head[32], head[31:0]); end
      end
      tests++; if (done_cnt0 !== CNT_W'(cnt_m0) || done_cnt1 !== CNT_W'(cnt_m1)) begin
        fails++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", cyc, done_cnt0, done_cnt1, cnt_m0, cnt_m1); end
      if (e_rv && rsp_ready) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          if (head[32]) cnt_m1++; else cnt_m0++;
        end
        inflight = 1'b0;
      end else if (inflight) begin
        age++;
      end
      if (e_r0) begin exp_q.push_back({1'b0, model_y(px0, ps0)}); pend0 = 1'b0; last_m = 1'b0; inflight = 1'b1; age = 1; end
      if (e_r1) begin exp_q.push_back({1'b1, model_y(px1, ps1)}); pend1 = 1'b0; last_m = 1'b1; inflight = 1'b1; age = 1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    int c;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_x = $urandom; req0_s = 1'b1; rsp_ready = 1'b1;
    n = 0; c = 0;
    while (n < (1 << CNT_W) + 1 && c < 3 * ((1 << CNT_W) + 1) + 20) begin
      #1;
      if (rsp_valid === 1'b1) n++;
      if (n == (1 << CNT_W) + 1) req0_valid = 1'b0;
      @(negedge clk); c++;
    end
    req0_valid = 1'b0;
    #1;
    tests++; if (n != (1 << CNT_W) + 1) begin fails++; $display("FAIL wrap_count got %0d exp %0d", n, (1 << CNT_W) + 1); end
    tests++; if (done_cnt0 !== CNT_W'(1) || done_cnt1 !== '0) begin
      fails++; $display("FAIL wrap_cnt got %0d/%0d exp 1/0", done_cnt0, done_cnt1); end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_x = '0; req0_s = 1'b0;
    req1_valid = 1'b0; req1_x = '0; req1_s = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog got timeout exp completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
